// File: rtl/amisha_wallace_mac.sv
// ---------------------------------------------------------------------------
// amisha_4bit_wallace
//   Unsigned 4x4 Wallace-tree multiplier. The sixteen partial products are
//   compressed in two carry-save layers of half/full adders down to two rows,
//   which a final carry-propagate add turns into the 8-bit product.
//   Ports:
//     a       in   4  multiplicand, unsigned
//     b       in   4  multiplier, unsigned
//     product out  8  a*b (0..225)
// ---------------------------------------------------------------------------
module amisha_4bit_wallace (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] product
);

   // Half adder: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Full adder: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   // pp_s[i][j] = a[j] & b[i], weight 2^(i+j)
   logic [3:0] pp_s [4];

   // Layer-1 compressors, named by the column weight of their sum bit.
   logic [1:0] l1_w1_s;
   logic [1:0] l1_w2_s;
   logic [1:0] l1_w3_s;
   logic [1:0] l1_w4_s;
   logic [1:0] l1_w5_s;

   // Layer-2 compressors.
   logic [1:0] l2_w3_s;
   logic [1:0] l2_w4_s;
   logic [1:0] l2_w5_s;
   logic [1:0] l2_w6_s;

   logic [7:0] row_x_s;
   logic [7:0] row_y_s;

   // Partial-product generation: one AND row per multiplier bit.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp_s[i] = a & {4{b[i]}};
      end
   end

   // Layer 1: column heights 1,2,3,4,3,2,1 reduced to at most 3.
   assign l1_w1_s = half_add(pp_s[0][1], pp_s[1][0]);
   assign l1_w2_s = full_add(pp_s[0][2], pp_s[1][1], pp_s[2][0]);
   assign l1_w3_s = full_add(pp_s[0][3], pp_s[1][2], pp_s[2][1]);
   assign l1_w4_s = full_add(pp_s[1][3], pp_s[2][2], pp_s[3][1]);
   assign l1_w5_s = half_add(pp_s[2][3], pp_s[3][2]);

   // Layer 2: column 3 still holds three bits; the half adders on 4..6 keep
   // the incoming carries from stacking a third bit into the next column.
   assign l2_w3_s = full_add(l1_w2_s[1], l1_w3_s[0], pp_s[3][0]);
   assign l2_w4_s = half_add(l1_w3_s[1], l1_w4_s[0]);
   assign l2_w5_s = half_add(l1_w4_s[1], l1_w5_s[0]);
   assign l2_w6_s = half_add(l1_w5_s[1], pp_s[3][3]);

   // Two remaining rows for the carry-propagate adder.
   assign row_x_s = {l2_w6_s[1], l2_w6_s[0], l2_w5_s[0], l2_w4_s[0],
                     l2_w3_s[0], l1_w2_s[0], l1_w1_s[0], pp_s[0][0]};
   assign row_y_s = {1'b0, l2_w5_s[1], l2_w4_s[1], l2_w3_s[1],
                     1'b0, l1_w1_s[1], 1'b0, 1'b0};

   // The true product never exceeds 225, so the 8-bit add cannot wrap.
   assign product = row_x_s + row_y_s;

endmodule

// ---------------------------------------------------------------------------
// amisha_wallace_mac
//   Multiply-accumulate stage: accepts LEN unsigned 4-bit operand pairs over a
//   valid/ready handshake, sums their products modulo 2^ACC_W and presents
//   the dot product (with a sticky carry-out flag) over a second handshake.
//   Parameters:
//     ACC_W  accumulator/result width (8..32)
//     LEN    products per result (1..255)
//   Ports:
//     clk             in   1      rising-edge clock
//     rst             in   1      asynchronous active-high reset
//     Data_in_valid   in   1      operand pair present
//     Data_in_ready   out  1      pair can be accepted (IDLE/ACCUM only)
//     Data_in_A       in   4      multiplicand
//     Data_in_B       in   4      multiplier
//     Data_out_valid  out  1      result available (DONE)
//     Data_out_ready  in   1      downstream takes the result
//     Data_out_Acc    out  ACC_W  sum of LEN products mod 2^ACC_W
//     Data_out_Ovf    out  1      some addition of this result carried out
// ---------------------------------------------------------------------------
module amisha_wallace_mac #(
   parameter int ACC_W = 12,
   parameter int LEN   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Data_in_valid,
   output logic             Data_in_ready,
   input  logic [3:0]       Data_in_A,
   input  logic [3:0]       Data_in_B,
   output logic             Data_out_valid,
   input  logic             Data_out_ready,
   output logic [ACC_W-1:0] Data_out_Acc,
   output logic             Data_out_Ovf
);

   localparam int CNT_W = $clog2(LEN + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_inc_s;
   logic             last_s;
   logic             open_s;
   logic             accept_s;
   logic             release_s;

   logic [3:0]       op_a_r;
   logic [3:0]       op_b_r;
   logic             op_v_r;
   logic [7:0]       product_s;

   logic [ACC_W-1:0] acc_r;
   logic             ovf_r;
   logic [ACC_W:0]   sum_s;
   logic [ACC_W-1:0] next_acc_s;
   logic             next_ovf_s;

   logic             out_valid_r;
   logic [ACC_W-1:0] out_acc_r;
   logic             out_ovf_r;

   amisha_4bit_wallace u_mult (
      .a       (op_a_r),
      .b       (op_b_r),
      .product (product_s)
   );

   // Input window: open in IDLE and ACCUM only.
   always_comb begin
      open_s = 1'b0;
      case (state_r)
         IDLE, ACCUM: open_s = 1'b1;
         default:     open_s = 1'b0;
      endcase
   end

   // Ready is forced low while rst is asserted even though state is IDLE.
   assign Data_in_ready = open_s & ~rst;
   assign accept_s      = Data_in_valid & Data_in_ready;
   assign count_inc_s   = count_r + CNT_W'(1'b1);
   assign last_s        = (count_inc_s == CNT_W'(LEN));
   assign release_s     = (state_r == DONE) & Data_out_ready;

   // Product zero-extended to ACC_W+1 bits so the top bit is the carry-out.
   assign sum_s = {1'b0, acc_r} + {{(ACC_W - 7){1'b0}}, product_s};

   // Accumulator update value: add only when stage 2 holds a valid pair.
   always_comb begin
      next_acc_s = acc_r;
      next_ovf_s = ovf_r;
      if (op_v_r) begin
         next_acc_s = sum_s[ACC_W-1:0];
         next_ovf_s = ovf_r | sum_s[ACC_W];
      end else begin
         next_acc_s = acc_r;
         next_ovf_s = ovf_r;
      end
   end

   // Next-state logic; the LEN-th transfer goes straight to FLUSH (also from IDLE when LEN=1).
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, ACCUM: begin
            if (accept_s) begin
               if (last_s) begin
                  next_state_s = FLUSH;
               end else begin
                  next_state_s = ACCUM;
               end
            end else begin
               next_state_s = state_r;
            end
         end
         FLUSH: next_state_s = DONE;
         DONE: begin
            if (Data_out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Transfer counter: counts accepted pairs, cleared as the vector closes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (state_r == FLUSH) begin
         count_r <= '0;
      end else if (accept_s) begin
         count_r <= count_inc_s;
      end
   end

   // Stage 1: operand registers; op_v drops on any edge without a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a_r <= 4'd0;
         op_b_r <= 4'd0;
         op_v_r <= 1'b0;
      end else begin
         op_v_r <= accept_s;
         if (accept_s) begin
            op_a_r <= Data_in_A;
            op_b_r <= Data_in_B;
         end
      end
   end

   // Stage 2: accumulator and sticky carry flag, cleared when the result is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= '0;
         ovf_r <= 1'b0;
      end else if (release_s) begin
         acc_r <= '0;
         ovf_r <= 1'b0;
      end else begin
         acc_r <= next_acc_s;
         ovf_r <= next_ovf_s;
      end
   end

   // Result registers: loaded with the final sum on the FLUSH edge, held until the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_acc_r   <= '0;
         out_ovf_r   <= 1'b0;
      end else if (state_r == FLUSH) begin
         out_valid_r <= 1'b1;
         out_acc_r   <= next_acc_s;
         out_ovf_r   <= next_ovf_s;
      end else if (release_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign Data_out_valid = out_valid_r;
   assign Data_out_Acc   = out_acc_r;
   assign Data_out_Ovf   = out_ovf_r;

endmodule

// File: tb/tb_amisha_wallace_mac.sv
// ---------------------------------------------------------------------------
// tb_amisha_wallace_mac
//   Three DUT instances: 0 = (ACC_W 12, LEN 4), 1 = (ACC_W 12, LEN 1),
//   2 = (ACC_W 8, LEN 4). One instance is active at a time. Inputs are driven
//   1 time unit after the rising edge; everything is sampled on the falling
//   edge. A scoreboard sums A*B with integer arithmetic per vector and
//   compares each consumed result against it.
// ---------------------------------------------------------------------------
module tb_amisha_wallace_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid  [3];
   logic [3:0] in_a      [3];
   logic [3:0] in_b      [3];
   logic       out_ready [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic       out_ovf   [3];
   logic [11:0] acc0;
   logic [11:0] acc1;
   logic [7:0]  acc2;

   int n_tests = 0;
   int n_fail  = 0;
   int act     = 0;   // active instance
   int mode    = 1;   // out_ready: 0 low, 1 high, 2 random

   // scoreboard state
   int   cyc = 0;
   int   last_cyc = 0;
   int   m_sum = 0;
   int   m_cnt = 0;
   logic m_ovf = 1'b0;
   int   exp_q [$];
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic prev_ovf = 1'b0;
   logic [31:0] prev_acc = 32'd0;

   amisha_wallace_mac #(.ACC_W(12), .LEN(4)) dut0 (
      .clk(clk), .rst(rst), .Data_in_valid(in_valid[0]), .Data_in_ready(in_ready[0]),
      .Data_in_A(in_a[0]), .Data_in_B(in_b[0]), .Data_out_valid(out_valid[0]),
      .Data_out_ready(out_ready[0]), .Data_out_Acc(acc0), .Data_out_Ovf(out_ovf[0]));

   amisha_wallace_mac #(.ACC_W(12), .LEN(1)) dut1 (
      .clk(clk), .rst(rst), .Data_in_valid(in_valid[1]), .Data_in_ready(in_ready[1]),
      .Data_in_A(in_a[1]), .Data_in_B(in_b[1]), .Data_out_valid(out_valid[1]),
      .Data_out_ready(out_ready[1]), .Data_out_Acc(acc1), .Data_out_Ovf(out_ovf[1]));

   amisha_wallace_mac #(.ACC_W(8), .LEN(4)) dut2 (
      .clk(clk), .rst(rst), .Data_in_valid(in_valid[2]), .Data_in_ready(in_ready[2]),
      .Data_in_A(in_a[2]), .Data_in_B(in_b[2]), .Data_out_valid(out_valid[2]),
      .Data_out_ready(out_ready[2]), .Data_out_Acc(acc2), .Data_out_Ovf(out_ovf[2]));

   function automatic int len_of(input int k);
      return (k == 1) ? 1 : 4;
   endfunction

   function automatic int width_of(input int k);
      return (k == 2) ? 8 : 12;
   endfunction

   function automatic logic [31:0] get_acc(input int k);
      case (k)
         0:       return {20'd0, acc0};
         1:       return {20'd0, acc1};
         default: return {24'd0, acc2};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Downstream ready generator.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         case (mode)
            0:       out_ready[k] = 1'b0;
            1:       out_ready[k] = 1'b1;
            default: out_ready[k] = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard: reference sums plus output-protocol checks on the active instance.
   always @(negedge clk) begin : scoreboard
      int k;
      int p;
      int e;
      cyc++;
      if (rst) begin
         m_sum = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
         exp_q.delete();
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         k = act;
         if (prev_valid && prev_ready)
            check_eq("valid_after_ack", 32'(out_valid[k]), 32'd0);
         if (out_valid[k]) begin
            check_eq("in_ready_in_done", 32'(in_ready[k]), 32'd0);
            if (!prev_valid)
               check_eq("latency", 32'(cyc - last_cyc), 32'd2);
            else if (!prev_ready) begin
               check_eq("hold_acc", get_acc(k), prev_acc);
               check_eq("hold_ovf", 32'(out_ovf[k]), 32'(prev_ovf));
            end
            if (out_ready[k]) begin
               check_eq("result_pending", 32'(exp_q.size()), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_eq("result_acc", get_acc(k), 32'(e & 32'hFFFF));
                  check_eq("result_ovf", 32'(out_ovf[k]), 32'(e >> 16));
               end
            end
         end
         if (in_valid[k] && in_ready[k]) begin
            p = int'(in_a[k]) * int'(in_b[k]);
            if (m_sum + p >= (1 << width_of(k))) m_ovf = 1'b1;
            m_sum = (m_sum + p) % (1 << width_of(k));
            m_cnt++;
            if (m_cnt == len_of(k)) begin
               exp_q.push_back((m_ovf ? 32'h10000 : 0) | m_sum);
               m_sum = 0;
               m_cnt = 0;
               m_ovf = 1'b0;
               last_cyc = cyc;
            end
         end
         prev_valid = out_valid[k];
         prev_ready = out_ready[k];
         prev_acc   = get_acc(k);
         prev_ovf   = out_ovf[k];
      end
   end

   // Offer one pair and keep it until it is taken; called and returns at posedge+1.
   task automatic send(input int k, input logic [3:0] a, input logic [3:0] b);
      int g = 0;
      in_a[k] = a;
      in_b[k] = b;
      in_valid[k] = 1'b1;
      @(negedge clk);
      while (!in_ready[k] && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) check_eq("send_timeout", 32'(in_ready[k]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait until every expected result of the active instance has been consumed.
   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || out_valid[act]) && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check_eq("drain_done", 32'(g < 300), 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int g;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0;
         in_a[k] = 4'd0;
         in_b[k] = 4'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_eq("rst_in_ready", 32'(in_ready[k]), 32'd0);
         check_eq("rst_out_valid", 32'(out_valid[k]), 32'd0);
         check_eq("rst_acc", get_acc(k), 32'd0);
         check_eq("rst_ovf", 32'(out_ovf[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_eq("ready_after_rst", 32'(in_ready[k]), 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back directed vector: 15+225+0+14 = 254.
      act = 0;
      send(0, 4'd3, 4'd5);
      send(0, 4'd15, 4'd15);
      send(0, 4'd0, 4'd9);
      send(0, 4'd7, 4'd2);
      drain();

      // LEN=1: every operand combination.
      act = 1;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            send(1, 4'(a), 4'(b));
      drain();

      // ACC_W=8: overflow then clean vector.
      act = 2;
      repeat (4) send(2, 4'd15, 4'd15);
      repeat (4) send(2, 4'd1, 4'd1);
      drain();

      // Backpressure: result held, pending pair waits.
      act = 0;
      mode = 0;
      repeat (4) send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      in_a[0] = 4'd2;
      in_b[0] = 4'd2;
      in_valid[0] = 1'b1;
      g = 0;
      while (!out_valid[0] && g < 20) begin
         @(negedge clk);
         g++;
      end
      check_eq("bp_reach_done", 32'(out_valid[0]), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
         check_eq("bp_valid", 32'(out_valid[0]), 32'd1);
      end
      mode = 1;
      @(posedge clk);
      #1;
      send(0, 4'd2, 4'd2);
      repeat (3) send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drain();

      // Gapped (2,3) x4 -> 24.
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         send(0, 4'd2, 4'd3);
      end
      drain();

      // Asynchronous reset between edges after two accepts.
      send(0, 4'd1, 4'd1);
      send(0, 4'd2, 4'd2);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
      check_eq("mid_rst_valid", 32'(out_valid[0]), 32'd0);
      check_eq("mid_rst_acc", get_acc(0), 32'd0);
      check_eq("mid_rst_ovf", 32'(out_ovf[0]), 32'd0);
      check_eq("mid_rst_acc_w8", get_acc(2), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) send(0, 4'd1, 4'd4);
      drain();

      // Random vectors with bubbles and random downstream ready.
      for (int k = 0; k < 3; k++) begin
         act = k;
         mode = 2;
         repeat (6) begin
            for (int i = 0; i < len_of(k); i++) begin
               idle($urandom_range(0, 2));
               send(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
         end
         mode = 1;
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
